mspe_recv_fifo: RTL and testbench

Receive-side buffer directly upstream of `mspe`. It accepts 512-bit Avalon-ST packets from the network/MAC side and stores them in a ring buffer. It presents them to `mspe` through the show-ahead `recv_fifo_*` read interface (`rdreq`/`q`/`rdusedw`/`valid`). It enforces sop/eop framing so `mspe` only ever sees words belonging to a packet that began with sop.

---
 rtl/mspe_recv_fifo.sv | 136 +++++++++++++
 tb/tb_mspe_recv_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mspe_recv_fifo.sv
// Receive ring buffer in front of mspe: sop/eop framing filter, show-ahead read port, full-level backpressure.
// Optional MSPE_RECV_FIFO_STATS_EN enables the live pkt_count/drop_count counters (tied to 0 otherwise).
module mspe_recv_fifo #(
    parameter int DEPTH_LOG2 = 10,
    parameter     DEVICE     = "ARTIX7"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [511:0]          snk_data,
    input  logic                  snk_valid,
    input  logic                  snk_sop,
    input  logic                  snk_eop,
    output logic                  snk_ready,
    input  logic                  recv_fifo_rdreq,
    output logic [511:0]          recv_fifo_q,
    output logic [DEPTH_LOG2:0]   recv_fifo_rdusedw,
    output logic                  recv_fifo_valid,
    output logic [31:0]           pkt_count,
    output logic [31:0]           drop_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_IN_PKT} state_t;

    state_t                 state_q;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]    count_q, count_d, ram_cnt;
    logic                   valid_q;
    logic [511:0]           ram_q;
    logic                   accept, wr_en, pop, ld_en;

    assign snk_ready = (count_q != FULL_CNT);
    assign accept    = snk_valid & snk_ready;
    assign wr_en     = accept & (snk_sop | (state_q == S_IN_PKT));
    assign pop       = recv_fifo_rdreq & valid_q;

    // Words still in RAM, excluding the one parked in the output register.
    assign ram_cnt = count_q - {{DEPTH_LOG2{1'b0}}, valid_q};
    assign ld_en   = (pop | ~valid_q) & (ram_cnt != '0);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else if (accept) begin
            if (snk_sop) begin
                state_q <= snk_eop ? S_IDLE : S_IN_PKT;
            end else if ((state_q == S_IN_PKT) && snk_eop) begin
                state_q <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (ld_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                valid_q  <= 1'b1;
            end else if (pop) begin
                valid_q  <= 1'b0;
            end
        end
    end

    // A load never targets the slot being written: writes need free space, loads need a stored word.
    if (DEVICE == "ARTIX7" || DEVICE == "KINTEX7" || DEVICE == "VIRTEX7") begin : g_ram_xil
        (* ram_style = "block" *) logic [511:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_ptr_q] <= snk_data;
            end
            if (ld_en) begin
                ram_q <= mem[rd_ptr_q];
            end
        end
    end else begin : g_ram_gen
        (* ramstyle = "no_rw_check" *) logic [511:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_ptr_q] <= snk_data;
            end
            if (ld_en) begin
                ram_q <= mem[rd_ptr_q];
            end
        end
    end

    // Masking with valid gives the async-zero head without a reset on the RAM output register.
    assign recv_fifo_q       = valid_q ? ram_q : '0;
    assign recv_fifo_valid   = valid_q;
    assign recv_fifo_rdusedw = count_q;

`ifdef MSPE_RECV_FIFO_STATS_EN
    logic [31:0] pkt_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (wr_en && snk_eop) begin
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
            if (accept && !snk_sop && (state_q == S_IDLE)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign pkt_count  = pkt_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    assign pkt_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_mspe_recv_fifo.sv
// Scoreboard bench for mspe_recv_fifo: framing model feeds an expected-word queue, reads pop and compare.
module tb_mspe_recv_fifo;

    localparam int DL = 10;
    localparam int D  = 1 << DL;
`ifdef MSPE_RECV_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic [511:0]   snk_data;
    logic           snk_valid, snk_sop, snk_eop, snk_ready;
    logic           recv_fifo_rdreq;
    logic [511:0]   recv_fifo_q;
    logic [DL:0]    recv_fifo_rdusedw;
    logic           recv_fifo_valid;
    logic [31:0]    pkt_count, drop_count;

    int             checks = 0;
    int             errors = 0;
    logic [511:0]   sb[$];
    int             m_pkt = 0;
    int             m_drop = 0;
    bit             m_inpkt = 1'b0;

    mspe_recv_fifo #(.DEPTH_LOG2(DL), .DEVICE("ARTIX7")) dut (
        .clk(clk), .reset(reset),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
        .snk_ready(snk_ready),
        .recv_fifo_rdreq(recv_fifo_rdreq), .recv_fifo_q(recv_fifo_q),
        .recv_fifo_rdusedw(recv_fifo_rdusedw), .recv_fifo_valid(recv_fifo_valid),
        .pkt_count(pkt_count), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] pat(input int n);
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = 32'(n * 16 + k) ^ 32'h5a5a_0000;
        return w;
    endfunction

    function automatic logic [31:0] exp_pkt();
        return STATS ? 32'(m_pkt) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_drop();
        return STATS ? 32'(m_drop) : 32'd0;
    endfunction

    // Called at a negedge; returns at the next negedge after one posedge has sampled the word.
    task automatic put(input bit sop, input bit eop, input logic [511:0] d);
        snk_valid = 1'b1; snk_sop = sop; snk_eop = eop; snk_data = d;
        if (snk_ready) begin
            if (sop) begin
                sb.push_back(d);
                m_inpkt = !eop;
                if (eop) m_pkt++;
            end else if (m_inpkt) begin
                sb.push_back(d);
                if (eop) begin m_pkt++; m_inpkt = 1'b0; end
            end else begin
                m_drop++;
            end
        end
        @(negedge clk);
        snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
        snk_data = '0; recv_fifo_rdreq = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (snk_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", snk_ready); end
        checks++; if (recv_fifo_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", recv_fifo_valid); end
        checks++; if (recv_fifo_q !== '0) begin errors++; $display("FAIL reset_q got=%h exp=0", recv_fifo_q[63:0]); end
        checks++; if (recv_fifo_rdusedw !== '0) begin errors++; $display("FAIL reset_rdusedw got=%0d exp=0", recv_fifo_rdusedw); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt got=%0d exp=0", pkt_count); end
        checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    endtask

    task automatic test_drain(input string tag);
        int guard = 0;
        recv_fifo_rdreq = 1'b1;
        while (sb.size() != 0 && guard < 3000) begin
            if (recv_fifo_valid === 1'b1) begin
                checks++;
                if (recv_fifo_q !== sb[0]) begin
                    errors++;
                    $display("FAIL %s_order got=%h exp=%h", tag, recv_fifo_q[63:0], sb[0][63:0]);
                end
                void'(sb.pop_front());
            end
            @(negedge clk);
            guard++;
        end
        recv_fifo_rdreq = 1'b0;
        checks++;
        if (guard >= 3000 || recv_fifo_valid !== 1'b0 || recv_fifo_rdusedw !== '0) begin
            errors++;
            $display("FAIL %s_empty valid=%b rdusedw=%0d left=%0d exp valid=0 rdusedw=0 left=0",
                     tag, recv_fifo_valid, recv_fifo_rdusedw, sb.size());
        end
    endtask

    task automatic test_single_word();
        logic [511:0] w;
        w = '0; w[31:0] = 32'd32; w[63:32] = 32'd3;
        put(1'b1, 1'b1, w);
        checks++; if (recv_fifo_rdusedw !== 11'd1) begin errors++; $display("FAIL single_rdusedw got=%0d exp=1", recv_fifo_rdusedw); end
        checks++; if (recv_fifo_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got=%b exp=0", recv_fifo_valid); end
        @(negedge clk);
        checks++; if (recv_fifo_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", recv_fifo_valid); end
        checks++; if (recv_fifo_q[63:0] !== 64'h3_0000_0020) begin errors++; $display("FAIL single_q got=%h exp=300000020", recv_fifo_q[63:0]); end
        checks++; if (pkt_count !== exp_pkt()) begin errors++; $display("FAIL single_pkt got=%0d exp=%0d", pkt_count, exp_pkt()); end
        test_drain("single");
    endtask

    task automatic test_burst_read();
        put(1'b1, 1'b0, pat(1));
        put(1'b0, 1'b0, pat(2));
        put(1'b0, 1'b1, pat(3));
        recv_fifo_rdreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (recv_fifo_rdusedw !== 11'(3 - i) || recv_fifo_valid !== 1'b1 || recv_fifo_q !== sb[0]) begin
                errors++;
                $display("FAIL burst_word%0d rdusedw=%0d valid=%b q=%h exp rdusedw=%0d valid=1 q=%h",
                         i, recv_fifo_rdusedw, recv_fifo_valid, recv_fifo_q[63:0], 3 - i, sb[0][63:0]);
            end
            void'(sb.pop_front());
            @(negedge clk);
        end
        recv_fifo_rdreq = 1'b0;
        checks++;
        if (recv_fifo_rdusedw !== '0 || recv_fifo_valid !== 1'b0) begin
            errors++; $display("FAIL burst_end rdusedw=%0d valid=%b exp 0/0", recv_fifo_rdusedw, recv_fifo_valid);
        end
    endtask

    task automatic test_orphans();
        put(1'b0, 1'b0, pat(10));
        put(1'b0, 1'b1, pat(11));
        put(1'b1, 1'b0, pat(12));
        put(1'b0, 1'b1, pat(13));
        checks++; if (recv_fifo_rdusedw !== 11'd2) begin errors++; $display("FAIL orphan_rdusedw got=%0d exp=2", recv_fifo_rdusedw); end
        checks++; if (drop_count !== exp_drop()) begin errors++; $display("FAIL orphan_drop got=%0d exp=%0d", drop_count, exp_drop()); end
        checks++; if (pkt_count !== exp_pkt()) begin errors++; $display("FAIL orphan_pkt got=%0d exp=%0d", pkt_count, exp_pkt()); end
        test_drain("orphan");
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < D; i++) put(i == 0, 1'b0, pat(100 + i));
        checks++; if (snk_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", snk_ready); end
        checks++; if (recv_fifo_rdusedw !== 11'(D)) begin errors++; $display("FAIL full_rdusedw got=%0d exp=%0d", recv_fifo_rdusedw, D); end
        put(1'b0, 1'b0, pat(5000));
        checks++; if (recv_fifo_rdusedw !== 11'(D)) begin errors++; $display("FAIL full_blocked got=%0d exp=%0d", recv_fifo_rdusedw, D); end
        recv_fifo_rdreq = 1'b1;
        checks++; if (recv_fifo_q !== sb[0]) begin errors++; $display("FAIL full_head got=%h exp=%h", recv_fifo_q[63:0], sb[0][63:0]); end
        void'(sb.pop_front());
        @(negedge clk);
        recv_fifo_rdreq = 1'b0;
        checks++; if (snk_ready !== 1'b1) begin errors++; $display("FAIL full_reready got=%b exp=1", snk_ready); end
        checks++; if (recv_fifo_rdusedw !== 11'(D - 1)) begin errors++; $display("FAIL full_pop_rdusedw got=%0d exp=%0d", recv_fifo_rdusedw, D - 1); end
        put(1'b0, 1'b1, pat(6000));
        checks++; if (recv_fifo_rdusedw !== 11'(D) || snk_ready !== 1'b0) begin
            errors++; $display("FAIL full_1025 rdusedw=%0d ready=%b exp=%0d/0", recv_fifo_rdusedw, snk_ready, D);
        end
        test_drain("wrap");
    endtask

    task automatic test_simul();
        for (int i = 0; i < 5; i++) put(i == 0, i == 4, pat(200 + i));
        checks++; if (recv_fifo_rdusedw !== 11'd5 || recv_fifo_valid !== 1'b1) begin
            errors++; $display("FAIL simul_pre rdusedw=%0d valid=%b exp=5/1", recv_fifo_rdusedw, recv_fifo_valid);
        end
        recv_fifo_rdreq = 1'b1;
        checks++; if (recv_fifo_q !== sb[0]) begin errors++; $display("FAIL simul_head got=%h exp=%h", recv_fifo_q[63:0], sb[0][63:0]); end
        void'(sb.pop_front());
        put(1'b1, 1'b1, pat(300));
        recv_fifo_rdreq = 1'b0;
        checks++; if (recv_fifo_rdusedw !== 11'd5) begin errors++; $display("FAIL simul_rdusedw got=%0d exp=5", recv_fifo_rdusedw); end
        test_drain("simul");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) put(i == 0, 1'b0, pat(400 + i));
        @(negedge clk);
        checks++; if (recv_fifo_rdusedw !== 11'd7 || recv_fifo_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre rdusedw=%0d valid=%b exp=7/1", recv_fifo_rdusedw, recv_fifo_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (recv_fifo_valid !== 1'b0 || recv_fifo_rdusedw !== '0 || recv_fifo_q !== '0) begin
            errors++; $display("FAIL rstmid_async valid=%b rdusedw=%0d q=%h exp 0/0/0", recv_fifo_valid, recv_fifo_rdusedw, recv_fifo_q[63:0]);
        end
        sb.delete(); m_inpkt = 1'b0; m_pkt = 0; m_drop = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        put(1'b0, 1'b1, pat(500));
        @(negedge clk);
        checks++; if (recv_fifo_rdusedw !== '0 || recv_fifo_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_orphan rdusedw=%0d valid=%b exp 0/0", recv_fifo_rdusedw, recv_fifo_valid);
        end
        checks++; if (drop_count !== exp_drop() || pkt_count !== exp_pkt()) begin
            errors++; $display("FAIL rstmid_counts drop=%0d pkt=%0d exp=%0d/%0d", drop_count, pkt_count, exp_drop(), exp_pkt());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst_read();
        test_orphans();
        test_full_wrap();
        test_simul();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
